// File: rtl/pla_seq_pkg.sv
// Shared types for the sequential PLA evaluator.
//   state_t   : evaluator FSM states (IDLE / EVAL / DONE)
//   cube_t    : one cube at the default geometry (care mask, required values, driven outputs)
//   idx_width : width of a term index/count able to hold 0..n_terms inclusive
package pla_seq_pkg;

  localparam int unsigned PLA_N_IN    = 22;
  localparam int unsigned PLA_N_OUT   = 1;
  localparam int unsigned PLA_N_TERMS = 64;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  typedef struct packed {
    logic [PLA_N_IN-1:0]  care;
    logic [PLA_N_IN-1:0]  val;
    logic [PLA_N_OUT-1:0] out;
  } cube_t;

  function automatic int unsigned idx_width(input int unsigned n_terms);
    return $clog2(n_terms) + 1;
  endfunction

endpackage

// File: rtl/pla_seq_eval_match.sv
// pla_term_match: combinational single-cube match.
//   in_vec_i : input vector under test
//   care_i   : 1 = bit participates in the cube
//   val_i    : required value where care_i = 1
//   hit_o    : 1 when every cared bit equals its required value
module pla_term_match
  import pla_seq_pkg::*;
#(
  parameter int unsigned N_IN = PLA_N_IN
) (
  input  logic [N_IN-1:0] in_vec_i,
  input  logic [N_IN-1:0] care_i,
  input  logic [N_IN-1:0] val_i,
  output logic            hit_o
);

  always_comb begin
    hit_o = (((in_vec_i ^ val_i) & care_i) == '0);
  end

endmodule

// File: rtl/pla_seq_eval.sv
// pla_seq_eval: sequential sum-of-products evaluator, one cube per clock.
// Optional build macro: PLA_EARLY_EXIT_EN -- leave EVAL as soon as every
// output bit is already set (results unchanged, latency may shrink).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_we/cfg_addr     : write cube {cfg_care, cfg_val, cfg_out} at cfg_addr
//   cfg_nterms_we       : load active cube count cfg_nterms (saturates at N_TERMS)
//                         and output phase mask cfg_inv
//   cfg_err             : one-cycle pulse when a config write arrives while busy
//   in_valid/in_ready   : input vector handshake (in_vec)
//   out_valid/out_ready : result handshake (out_vec)
//   busy                : high while evaluating or holding a result
module pla_seq_eval
  import pla_seq_pkg::*;
#(
  parameter int unsigned N_IN    = 22,
  parameter int unsigned N_OUT   = 1,
  parameter int unsigned N_TERMS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
  input  logic [N_IN-1:0]            cfg_care,
  input  logic [N_IN-1:0]            cfg_val,
  input  logic [N_OUT-1:0]           cfg_out,
  input  logic                       cfg_nterms_we,
  input  logic [$clog2(N_TERMS):0]   cfg_nterms,
  input  logic [N_OUT-1:0]           cfg_inv,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT-1:0]           out_vec,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(N_TERMS);
  localparam int unsigned IW = idx_width(N_TERMS);

  typedef struct packed {
    logic [N_IN-1:0]  care;
    logic [N_IN-1:0]  val;
    logic [N_OUT-1:0] out;
  } term_t;

  term_t            mem_q [N_TERMS];
  state_t           state_q;
  logic [IW-1:0]    nterms_q;
  logic [IW-1:0]    idx_q;
  logic [N_OUT-1:0] inv_q;
  logic [N_OUT-1:0] acc_q;
  logic [N_OUT-1:0] out_vec_q;
  logic [N_IN-1:0]  vec_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             cfg_err_q;

  logic             cfg_ok;
  logic [IW-1:0]    nterms_sat;
  logic [IW-1:0]    nterms_eff;
  logic [N_OUT-1:0] inv_eff;
  term_t            cur;
  logic             hit;
  logic [N_OUT-1:0] acc_d;
  logic             last_term;
  logic             eval_done;

  always_comb begin
    cfg_ok     = (state_q == IDLE);
    nterms_sat = (cfg_nterms > IW'(N_TERMS)) ? IW'(N_TERMS) : cfg_nterms;
    // A count/phase write in the accepting cycle lands first, so the
    // accept decision must already see the new values.
    nterms_eff = cfg_nterms_we ? nterms_sat : nterms_q;
    inv_eff    = cfg_nterms_we ? cfg_inv : inv_q;
    cur        = mem_q[idx_q[AW-1:0]];
  end

  pla_term_match #(
    .N_IN (N_IN)
  ) u_match (
    .in_vec_i (vec_q),
    .care_i   (cur.care),
    .val_i    (cur.val),
    .hit_o    (hit)
  );

  always_comb begin
    acc_d     = acc_q | (hit ? cur.out : '0);
    last_term = (idx_q == (nterms_q - IW'(1)));
`ifdef PLA_EARLY_EXIT_EN
    eval_done = last_term || (&acc_d);
`else
    eval_done = last_term;
`endif
  end

  // Cube storage is deliberately not reset; only entries below nterms are read.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ok) begin
      mem_q[cfg_addr].care <= cfg_care;
      mem_q[cfg_addr].val  <= cfg_val;
      mem_q[cfg_addr].out  <= cfg_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nterms_q    <= '0;
      inv_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      vec_q       <= '0;
      out_vec_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= (cfg_we || cfg_nterms_we) && !cfg_ok;
      if (cfg_nterms_we && cfg_ok) begin
        nterms_q <= nterms_sat;
        inv_q    <= cfg_inv;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q      <= in_vec;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (nterms_eff == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_vec_q   <= inv_eff;
            end else begin
              state_q <= EVAL;
            end
          end
        end
        EVAL: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IW'(1);
          if (eval_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_vec_q   <= acc_d ^ inv_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_vec   = out_vec_q;
    busy      = busy_q;
    cfg_err   = cfg_err_q;
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Scoreboard bench for pla_seq_eval: the driver pushes the model's expected
// {result, latency} at every accept; a monitor pops and compares on each
// result handshake and also drives out_ready.
module tb_pla_seq_eval;

  localparam int N_IN    = 22;
  localparam int N_OUT   = 1;
  localparam int N_TERMS = 64;
  localparam int AW      = 6;
  localparam int IW      = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [N_IN-1:0]  cfg_care = '0;
  logic [N_IN-1:0]  cfg_val = '0;
  logic [N_OUT-1:0] cfg_out = '0;
  logic             cfg_nterms_we = 1'b0;
  logic [IW-1:0]    cfg_nterms = '0;
  logic [N_OUT-1:0] cfg_inv = '0;
  logic             cfg_err;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N_OUT-1:0] out_vec;
  logic             busy;

  pla_seq_eval #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .N_TERMS (N_TERMS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_care      (cfg_care),
    .cfg_val       (cfg_val),
    .cfg_out       (cfg_out),
    .cfg_nterms_we (cfg_nterms_we),
    .cfg_nterms    (cfg_nterms),
    .cfg_inv       (cfg_inv),
    .cfg_err       (cfg_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_vec        (in_vec),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_vec       (out_vec),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [N_OUT-1:0] vec;
    int               lat;
    int               acc;
  } exp_t;
  exp_t sbq[$];

  // Reference cover: what the DUT should hold after legal (idle) writes.
  logic [N_IN-1:0]  m_care [N_TERMS];
  logic [N_IN-1:0]  m_val  [N_TERMS];
  logic [N_OUT-1:0] m_out  [N_TERMS];
  int               m_n = 0;
  logic [N_OUT-1:0] m_inv = '0;

  int rdy_mode = 2;  // 0 random, 1 hold low, 2 always high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(input logic [N_IN-1:0] v);
    exp_t e;
    logic [N_OUT-1:0] acc = '0;
    int lat = m_n + 1;
    bit sat = 1'b0;
    for (int i = 0; i < m_n; i++) begin
      if (((v ^ m_val[i]) & m_care[i]) == '0) acc |= m_out[i];
`ifdef PLA_EARLY_EXIT_EN
      if (!sat && acc == {N_OUT{1'b1}}) begin
        sat = 1'b1;
        lat = i + 2;
      end
`endif
    end
    e.vec = acc ^ m_inv;
    e.lat = lat;
    e.acc = 0;
    return e;
  endfunction

  // Monitor: drives out_ready, checks hold stability and scoreboard results.
  logic             seen = 1'b0;
  int               rise = 0;
  logic [N_OUT-1:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          rise = cyc;
          held = out_vec;
        end else begin
          check("out_vec_hold", 32'(out_vec), 32'(held));
        end
      end
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready) begin
        seen = 1'b0;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got out_vec 0x%0h, required no result", out_vec);
        end else begin
          e = sbq.pop_front();
          check("out_vec", 32'(out_vec), 32'(e.vec));
          check("latency", 32'(rise - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || !in_ready || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic send(input logic [N_IN-1:0] v);
    exp_t e;
    int n = 0;
    @(negedge clk);
    in_vec   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0 after %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    e = predict(v);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wr_cube(input int a, input logic [N_IN-1:0] c, input logic [N_IN-1:0] v,
                         input logic [N_OUT-1:0] o, input bit busy_exp);
    if (!busy_exp) wait_idle();
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_care = c;
    cfg_val  = v;
    cfg_out  = o;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_on_write", 32'(cfg_err), 32'(busy_exp));
    if (busy_exp) begin
      @(negedge clk);
      check("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    end else begin
      m_care[a] = c;
      m_val[a]  = v;
      m_out[a]  = o;
    end
  endtask

  task automatic set_n(input int n, input logic [N_OUT-1:0] inv);
    wait_idle();
    @(negedge clk);
    cfg_nterms_we = 1'b1;
    cfg_nterms    = IW'(n);
    cfg_inv       = inv;
    @(negedge clk);
    cfg_nterms_we = 1'b0;
    m_n   = (n > N_TERMS) ? N_TERMS : n;
    m_inv = inv;
  endtask

  // Cube write, count load and accept all in one idle cycle.
  task automatic send_with_cfg(input int a, input logic [N_IN-1:0] c, input logic [N_IN-1:0] v,
                               input logic [N_OUT-1:0] o, input int n, input logic [N_IN-1:0] vec);
    exp_t e;
    wait_idle();
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_care = c; cfg_val = v; cfg_out = o;
    cfg_nterms_we = 1'b1; cfg_nterms = IW'(n); cfg_inv = '0;
    in_vec = vec; in_valid = 1'b1;
    m_care[a] = c; m_val[a] = v; m_out[a] = o;
    m_n = (n > N_TERMS) ? N_TERMS : n;
    m_inv = '0;
    e = predict(vec);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    cfg_we = 1'b0; cfg_nterms_we = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    int n_hi;
    logic [N_IN-1:0] v;

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_vec", 32'(out_vec), 32'd0);
    check("reset_cfg_err", 32'(cfg_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // nterms=0 with inverted phase
    set_n(0, 1'b1);
    send('0);
    wait_idle();

    // single cube on bit 0
    wr_cube(0, 22'h000001, 22'h000001, 1'b1, 1'b0);
    set_n(1, 1'b0);
    send(22'h000001);
    send(22'h000000);
    wait_idle();

    // 64 cubes, only the last one matches vector 0
    for (int i = 0; i < 63; i++) wr_cube(i, '1, '1, 1'b1, 1'b0);
    wr_cube(63, '0, '0, 1'b1, 1'b0);
    set_n(64, 1'b0);
    send('0);
    wait_idle();
    wr_cube(0, '0, '0, 1'b1, 1'b0);
    send('0);
    wait_idle();
    wr_cube(0, '1, '1, 1'b1, 1'b0);

    // count saturation
    set_n(100, 1'b0);
    send(22'h000123);
    wait_idle();

    // backpressure: result held, no new accept
    rdy_mode = 1;
    send('0);
    n_hi = 0;
    while (!out_valid && n_hi < 200) begin
      @(negedge clk);
      n_hi++;
    end
    check("bp_out_valid_rise", 32'(out_valid), 32'd1);
    in_vec   = 22'h0ABCDE;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);

    // config write while evaluating is dropped
    send('0);
    repeat (3) @(negedge clk);
    check("busy_in_eval", 32'(busy), 32'd1);
    wr_cube(63, '1, '1, 1'b0, 1'b1);
    wait_idle();
    send('0);
    wait_idle();

    // reset in the middle of an evaluation
    send('0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    m_n   = 0;
    m_inv = '0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_hi = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (out_valid) n_hi++;
    end
    check("midrst_no_output", 32'(n_hi), 32'd0);
    send(22'h3FFFFF);
    wait_idle();

    // same-cycle cube write + count load + accept
    send_with_cfg(5, '0, '0, 1'b1, 6, 22'h000000);
    wait_idle();

    // randomized covers, counts and vectors
    rdy_mode = 0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_TERMS; i++)
        wr_cube(i, N_IN'($urandom & $urandom & $urandom), N_IN'($urandom),
                N_OUT'($urandom_range(0, 1)), 1'b0);
      set_n($urandom_range(0, 70), N_OUT'($urandom_range(0, 1)));
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 5) == 0) set_n($urandom_range(0, 70), N_OUT'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 0) v = m_val[$urandom_range(0, N_TERMS - 1)];
        else v = N_IN'($urandom);
        send(v);
      end
      wait_idle();
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required $finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pla_seq_eval.md
Name: pla_seq_eval

Overview:
- Sequential, parametrised successor to our flattened single-output PLA netlists (22 inputs, 1 output).
- Evaluates a programmable sum-of-products cover with N_IN inputs, N_OUT outputs and up to N_TERMS cubes, one cube per clock.
- Input vectors arrive over a valid/ready handshake; results leave over a second valid/ready handshake.
- The cover is loaded at runtime through a config port, so any benchmark PLA can be evaluated without resynthesis.

Parameters:
N_IN, 22, number of PLA inputs
N_OUT, 1, number of PLA outputs
N_TERMS, 64, cube memory depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  write cube at cfg_addr
cfg_addr  in  $clog2(N_TERMS)  cube index
cfg_care  in  N_IN  1 = input bit participates in cube
cfg_val  in  N_IN  required value where care=1
cfg_out  in  N_OUT  outputs this cube drives
cfg_nterms_we  in  1  load active term count
cfg_nterms  in  $clog2(N_TERMS)+1  active cubes, 0..N_TERMS
cfg_inv  in  N_OUT  output phase mask, sampled with cfg_nterms_we
cfg_err  out  1  one-cycle pulse: config write dropped
in_valid  in  1  input vector valid
in_ready  out  1  block accepts vector
in_vec  in  N_IN  input vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_vec  out  N_OUT  result
busy  out  1  high in EVAL or DONE

Behaviour:
- Reset values: nterms=0, inv=0, state=IDLE, in_ready=1, out_valid=0, out_vec=0, cfg_err=0, busy=0. Cube memory is not reset; entries at or above nterms are never read.
- Cube match rule: ((in_vec ^ cfg_val) & cfg_care) == 0. An all-zero care mask matches every vector.
- FSM states: IDLE, EVAL, DONE.
  - IDLE: in_ready=1. On in_valid, latch in_vec, clear acc, set idx=0. If nterms==0, go to DONE; otherwise go to EVAL.
  - EVAL: each cycle, if cube[idx] matches, acc |= cube_out[idx]; then idx++. After idx==nterms-1 has been processed, go to DONE.
  - DONE: out_valid=1, out_vec = acc ^ inv. Hold both stable until out_ready. Return to IDLE on the cycle out_valid && out_ready.
- Latency: accept to out_valid is nterms+1 cycles (1 cycle when nterms==0). Throughput is one vector per nterms+2 cycles; in_ready is low outside IDLE, so there is no overlap.
- Config writes are honoured only when busy==0. A write while busy is dropped and cfg_err pulses for one cycle.
- cfg_we and cfg_nterms_we in the same idle cycle both take effect.
- cfg_nterms > N_TERMS saturates to N_TERMS.
- A config write and an in_valid accept in the same idle cycle: the write lands first, so the new cube or count is used by that evaluation.
- idx is $clog2(N_TERMS)+1 wide, so it cannot wrap when nterms==N_TERMS.
- Asserting rst_n low mid-evaluation aborts the evaluation immediately, with no partial output; all registers return to their reset values.

Optional Feature:
PLA_EARLY_EXIT_EN
- Defined: in EVAL, once (acc | hit contribution) is all ones across N_OUT, jump to DONE next cycle. Latency becomes min(first saturating idx+2, nterms+1).
- Undefined: all nterms cubes are always scanned, giving fixed latency nterms+1.
- Outputs are identical in both builds; only timing differs.

Decomposition:
- Package pla_seq_pkg holds:
  - state enum (IDLE/EVAL/DONE)
  - cube_t struct {care, val, out} parameterised via localparams
  - helper function for idx width
- Sub-module pla_term_match: purely combinational cube match (in_vec, care, val -> hit). It is reused later for multi-lane evaluation.

Test Plan:
- Reset then nterms=0, inv=1, vector 0 -> out_valid after 1 cycle, out_vec=1, matching our complemented-output benchmarks.
- N_IN=22; cube0 care=0x000001 val=0x000001 out=1; nterms=1; in_vec=0x000001 -> out_vec=1 after 2 cycles. Same setup with in_vec=0x000000 -> out_vec=0.
- nterms=64, only cube63 matches -> out_vec=1 exactly 65 cycles after accept. With PLA_EARLY_EXIT_EN and cube0 all-don't-care, out_valid comes after 2 cycles.
- out_ready held low 10 cycles in DONE -> out_vec stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> back to IDLE next cycle.
- cfg_we asserted during EVAL -> cfg_err pulses 1 cycle and the cube memory readback result is unchanged on the next evaluation.
- rst_n pulsed low at EVAL idx=5 -> out_valid never rises for that vector. After reset, nterms=0, state=IDLE, in_ready=1.
